sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters: AWIDTH, default 10, row-address width; BWIDTH, default 256, data and bit-enable width.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high. Ports:
- CLK, input, 1: rising-edge clock.
- RST, input, 1: asynchronous, active-high reset.
REQ-003 Requester ports, one set each for N = 0 and N = 1:
- reqN_valid, input, 1: request present.
- reqN_ready, output, 1: request accepted this cycle.
- reqN_we, input, 1: 1 = write, 0 = read.
- reqN_last, input, 1: final beat of a burst.
- reqN_addr, input, AWIDTH: row address.
- reqN_be, input, BWIDTH: bit enable.
- reqN_wdata, input, BWIDTH: write data.
REQ-004 Response ports, one set each for N = 0 and N = 1:
- rspN_valid, output, 1: read data valid this cycle.
- rspN_rdata, output, BWIDTH: read data.
REQ-005 SRAM-side ports:
- CSn, output, 1: chip select, active-low.
- WEn, output, 1: write enable, active-low.
- ADDR, output, AWIDTH: row address.
- BE, output, BWIDTH: bit enable.
- D_in, output, BWIDTH: write data.
- D_out, input, BWIDTH: SRAM read data.

Function
REQ-006 The block SHALL issue at most one SRAM access per cycle. An access is issued in a cycle where some reqN_valid && reqN_ready holds.
REQ-007 reqN_ready SHALL be combinational from the valids, the state and the priority pointer. At most one ready is high per cycle.
REQ-008 State machine states SHALL be IDLE, LOCK0 and LOCK1.
- IDLE: grant a single requester. If only one is valid, grant it. If both are valid, grant the one indicated by the priority pointer prio; prio = 0 favours requester 0.
- LOCKn: only requester n may be granted; the other requester's ready is held 0.
REQ-009 Transitions SHALL be:
- IDLE -> LOCKn when requester n is granted with reqn_last = 0.
- IDLE stays IDLE when the grant has last = 1.
- LOCKn -> IDLE when requester n is granted with reqn_last = 1.
- LOCKn stays LOCKn while reqn_valid = 0. Idle cycles inside a burst do not release the lock.
REQ-010 prio SHALL toggle to the non-granted requester on every accepted beat that has last = 1. prio SHALL be unchanged otherwise.
REQ-011 On an issued beat, the SRAM outputs SHALL be driven combinationally from the granted requester:
- CSn = 0.
- WEn = ~we.
- ADDR = addr.
- BE = be.
- D_in = wdata.
REQ-012 With no grant, the SRAM outputs SHALL be CSn = 1, WEn = 1, ADDR = 0, BE = 0, D_in = 0.
REQ-013 For an issued read by requester n, rspn_valid SHALL be 1 in exactly the following cycle. rspN_rdata SHALL be D_out passed through unregistered.
- Read latency is 1 cycle from issue to response.
- Back-to-back reads yield back-to-back responses in issue order.
REQ-014 The block SHALL hold a registered pending-response flag and owner id. rsp1_valid and rsp0_valid SHALL never both be 1.
REQ-015 Writes SHALL produce no response.
REQ-016 Simultaneous-event rules:
- A response for one requester may coincide with a new grant to either requester.
- A write may issue in the cycle a read response is returned.
REQ-017 Requesters SHALL hold valid, addr, be, wdata, we and last stable while valid = 1 and ready = 0. The block does not buffer requests.

Reset
REQ-018 While RST = 1, the block SHALL hold the following asynchronously:
- state = IDLE, prio = 0.
- Pending-response flag cleared.
- req0_ready = req1_ready = 0; rsp0_valid = rsp1_valid = 0.
- CSn = 1, WEn = 1, ADDR = 0, BE = 0, D_in = 0.
REQ-019 Reset asserted mid-burst or with a read outstanding SHALL abandon the burst and drop the response. The first cycle after RST falls behaves as IDLE with prio = 0.

Verification
REQ-020 Single read: req0 reads addr 0x005 with last = 1, SRAM preloaded 0x005 = 0xA5.
- Cycle 0: req0_ready = 1, CSn = 0, WEn = 1, ADDR = 0x005.
- Cycle 1: rsp0_valid = 1, rsp0_rdata = 0xA5.
REQ-021 Masked write then read: req1 writes addr 0x010 with D = all-ones, BE = 0x0F, over old data 0; then reads addr 0x010.
- The read returns 0x0F on rsp1_rdata one cycle after the read issue.
REQ-022 Round-robin: both requesters continuously valid, single-beat reads (last = 1) from reset.
- Grants alternate 0,1,0,1.
- Responses alternate rsp0, rsp1 with 1-cycle lag.
- req0_ready and req1_ready are never both high.
REQ-023 Burst lock: req0 issues a 4-beat burst (last on beat 4) with a 1-cycle valid gap after beat 2, while req1 is valid throughout.
- req1_ready = 0 until the cycle after beat 4 is accepted.
- That following cycle, req1_ready = 1.
REQ-024 Reset mid-operation: RST pulsed in the cycle after a req0 read issues, while in LOCK0.
- rsp0_valid stays 0 and CSn = 1 during reset.
- After release, a req1-only request is granted immediately.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Bundle of requester, response and SRAM-side signals for sram_arbiter.
// master = requesters plus the SRAM macro; slave = the arbiter.
interface sram_arbiter_if #(
    parameter int AWIDTH = 10,
    parameter int BWIDTH = 256
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic              req0_last;
    logic [AWIDTH-1:0] req0_addr;
    logic [BWIDTH-1:0] req0_be;
    logic [BWIDTH-1:0] req0_wdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic              req1_last;
    logic [AWIDTH-1:0] req1_addr;
    logic [BWIDTH-1:0] req1_be;
    logic [BWIDTH-1:0] req1_wdata;

    logic              rsp0_valid;
    logic [BWIDTH-1:0] rsp0_rdata;
    logic              rsp1_valid;
    logic [BWIDTH-1:0] rsp1_rdata;

    logic              CSn;
    logic              WEn;
    logic [AWIDTH-1:0] ADDR;
    logic [BWIDTH-1:0] BE;
    logic [BWIDTH-1:0] D_in;
    logic [BWIDTH-1:0] D_out;

    modport master (
        output req0_valid, req0_we, req0_last, req0_addr, req0_be, req0_wdata,
        output req1_valid, req1_we, req1_last, req1_addr, req1_be, req1_wdata,
        output D_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        input  CSn, WEn, ADDR, BE, D_in
    );

    modport slave (
        input  req0_valid, req0_we, req0_last, req0_addr, req0_be, req0_wdata,
        input  req1_valid, req1_we, req1_last, req1_addr, req1_be, req1_wdata,
        input  D_out,
        output req0_ready, req1_ready, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
        output CSn, WEn, ADDR, BE, D_in
    );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester single-port SRAM arbiter with round-robin priority and burst locking.
// Reads return D_out one cycle after issue on the issuing requester's response port.
module sram_arbiter #(
    parameter int AWIDTH = 10,
    parameter int BWIDTH = 256
) (
    input  logic          CLK,
    input  logic          RST,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t state;
    logic   prio;
    logic   pend;
    logic   pend_id;

    logic   g0;
    logic   g1;
    logic   gnt_we;
    logic   gnt_last;

    // Grants are gated by RST so ready and the SRAM strobes are quiet during reset.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!RST) begin
            unique case (state)
                IDLE: begin
                    g0 = bus.req0_valid && (!bus.req1_valid || !prio);
                    g1 = bus.req1_valid && (!bus.req0_valid ||  prio);
                end
                LOCK0: g0 = bus.req0_valid;
                LOCK1: g1 = bus.req1_valid;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.CSn  = 1'b1;
        bus.WEn  = 1'b1;
        bus.ADDR = '0;
        bus.BE   = '0;
        bus.D_in = '0;
        gnt_we   = 1'b0;
        gnt_last = 1'b0;
        if (g0) begin
            bus.CSn  = 1'b0;
            bus.WEn  = ~bus.req0_we;
            bus.ADDR = bus.req0_addr;
            bus.BE   = bus.req0_be;
            bus.D_in = bus.req0_wdata;
            gnt_we   = bus.req0_we;
            gnt_last = bus.req0_last;
        end else if (g1) begin
            bus.CSn  = 1'b0;
            bus.WEn  = ~bus.req1_we;
            bus.ADDR = bus.req1_addr;
            bus.BE   = bus.req1_be;
            bus.D_in = bus.req1_wdata;
            gnt_we   = bus.req1_we;
            gnt_last = bus.req1_last;
        end
    end

    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;
    assign bus.rsp0_valid = pend && !pend_id;
    assign bus.rsp1_valid = pend &&  pend_id;
    assign bus.rsp0_rdata = bus.D_out;
    assign bus.rsp1_rdata = bus.D_out;

    // A last beat releases the lock and hands priority to the other requester.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            prio    <= 1'b0;
            pend    <= 1'b0;
            pend_id <= 1'b0;
        end else begin
            pend    <= (g0 || g1) && !gnt_we;
            pend_id <= g1;
            if (g0 || g1) begin
                if (gnt_last) begin
                    state <= IDLE;
                    prio  <= g0;
                end else begin
                    state <= g0 ? LOCK0 : LOCK1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed scenarios then randomized bursts,
// checked against a reference model of arbitration rules and memory contents.
module tb_sram_arbiter;
    localparam int AW = 10;
    localparam int BW = 256;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int            id;
        logic [BW-1:0] data;
        int            due;
    } exp_t;

    logic CLK;
    logic RST;
    sram_arbiter_if #(.AWIDTH(AW), .BWIDTH(BW)) bus ();

    sram_arbiter #(.AWIDTH(AW), .BWIDTH(BW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    exp_t sb[$];

    logic [1:0]    v;
    logic [1:0]    we;
    logic [1:0]    last;
    logic [AW-1:0] addr [2];
    logic [BW-1:0] be   [2];
    logic [BW-1:0] wd   [2];
    int            rem  [2];
    logic [1:0]    acc;

    logic [BW-1:0] mem     [DEPTH];
    logic [BW-1:0] ref_mem [DEPTH];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [BW-1:0] init_word(int unsigned i);
        if (i == 5)  return 256'hA5;
        if (i == 16) return '0;
        return {8{(i * 32'h9E3779B1) ^ 32'h5A5A5A5A}};
    endfunction

    function automatic logic [BW-1:0] rnd256();
        logic [BW-1:0] r;
        for (int k = 0; k < BW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void check(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    // SRAM macro: registered read, bit-masked write.
    initial begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] = init_word(i);
        bus.D_out = '0;
        forever begin
            @(posedge CLK);
            if (!bus.CSn) begin
                if (!bus.WEn) mem[bus.ADDR] = (mem[bus.ADDR] & ~bus.BE) | (bus.D_in & bus.BE);
                else          bus.D_out <= mem[bus.ADDR];
            end
        end
    end

    // Reference model: lock owner (-1 = none) and favoured requester.
    initial begin
        int lock_owner;
        int fav;
        logic e0, e1;
        int n;
        logic [AW-1:0] a;
        logic [BW-1:0] b, d;
        logic w, l;
        lock_owner = -1;
        fav = 0;
        acc = '0;
        for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        forever begin
            @(negedge CLK);
            if (RST) begin
                check("rst_ready0", bus.req0_ready, 0);
                check("rst_ready1", bus.req1_ready, 0);
                check("rst_csn", bus.CSn, 1);
                check("rst_wen", bus.WEn, 1);
                check("rst_addr", bus.ADDR, 0);
                check("rst_be", bus.BE, 0);
                check("rst_din", bus.D_in, 0);
                lock_owner = -1;
                fav = 0;
                acc = '0;
            end else begin
                if (lock_owner == 0)      begin e0 = bus.req0_valid; e1 = 1'b0; end
                else if (lock_owner == 1) begin e0 = 1'b0; e1 = bus.req1_valid; end
                else if (bus.req0_valid && bus.req1_valid) begin
                    e0 = (fav == 0);
                    e1 = (fav == 1);
                end else begin
                    e0 = bus.req0_valid;
                    e1 = bus.req1_valid;
                end
                check("ready0", bus.req0_ready, e0);
                check("ready1", bus.req1_ready, e1);
                if (e0 || e1) begin
                    n = e1 ? 1 : 0;
                    a = n ? bus.req1_addr  : bus.req0_addr;
                    b = n ? bus.req1_be    : bus.req0_be;
                    d = n ? bus.req1_wdata : bus.req0_wdata;
                    w = n ? bus.req1_we    : bus.req0_we;
                    l = n ? bus.req1_last  : bus.req0_last;
                    check("csn", bus.CSn, 0);
                    check("wen", bus.WEn, !w);
                    check("addr", bus.ADDR, a);
                    check("be", bus.BE, b);
                    check("din", bus.D_in, d);
                    if (w) ref_mem[a] = (ref_mem[a] & ~b) | (d & b);
                    else   sb.push_back('{id: n, data: ref_mem[a], due: cyc + 1});
                    if (l) begin lock_owner = -1; fav = 1 - n; end
                    else   lock_owner = n;
                end else begin
                    check("idle_csn", bus.CSn, 1);
                    check("idle_wen", bus.WEn, 1);
                    check("idle_addr", bus.ADDR, 0);
                    check("idle_be", bus.BE, 0);
                    check("idle_din", bus.D_in, 0);
                end
                acc = {e1, e0};
            end
        end
    end

    // Response monitor: pops the scoreboard whenever a response is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            check("rsp_excl", bus.rsp0_valid & bus.rsp1_valid, 0);
            if (RST) begin
                check("rst_rsp0", bus.rsp0_valid, 0);
                check("rst_rsp1", bus.rsp1_valid, 0);
                sb.delete();
            end else if (bus.rsp0_valid || bus.rsp1_valid) begin
                if (sb.size() == 0) begin
                    check("rsp_spurious", bus.rsp0_valid | bus.rsp1_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", bus.rsp1_valid, e.id);
                    check("rsp_lat", cyc, e.due);
                    check("rsp_data", bus.rsp1_valid ? bus.rsp1_rdata : bus.rsp0_rdata, e.data);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("rsp_valid", bus.rsp0_valid | bus.rsp1_valid, 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic apply();
        bus.req0_valid = v[0];  bus.req1_valid = v[1];
        bus.req0_we    = we[0]; bus.req1_we    = we[1];
        bus.req0_last  = last[0]; bus.req1_last = last[1];
        bus.req0_addr  = addr[0]; bus.req1_addr = addr[1];
        bus.req0_be    = be[0]; bus.req1_be    = be[1];
        bus.req0_wdata = wd[0]; bus.req1_wdata = wd[1];
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(int n, logic vv, logic w, logic l, logic [AW-1:0] a,
                           logic [BW-1:0] b, logic [BW-1:0] d);
        v[n] = vv; we[n] = w; last[n] = l; addr[n] = a; be[n] = b; wd[n] = d;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        v = '0;
        rem[0] = 0;
        rem[1] = 0;
        apply();
        step();
        step();
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        v = '0; we = '0; last = '0;
        for (int n = 0; n < 2; n++) begin
            addr[n] = '0; be[n] = '0; wd[n] = '0; rem[n] = 0;
        end
        apply();
        step(); step(); step();
        RST = 1'b0;

        // Single read of preloaded 0x005
        set_req(0, 1, 0, 1, 10'h005, '1, '0);
        apply(); #3;
        check("t1_ready0", bus.req0_ready, 1);
        check("t1_csn", bus.CSn, 0);
        check("t1_addr", bus.ADDR, 10'h005);
        step(); v[0] = 0; apply(); #3;
        check("t1_rsp0_valid", bus.rsp0_valid, 1);
        check("t1_rsp0_rdata", bus.rsp0_rdata, 256'hA5);
        step();

        // Masked write then read of 0x010
        set_req(1, 1, 1, 1, 10'h010, 256'h0F, '1);
        apply(); step();
        set_req(1, 1, 0, 1, 10'h010, '1, '0);
        apply(); step();
        v[1] = 0; apply(); #3;
        check("t2_rsp1_valid", bus.rsp1_valid, 1);
        check("t2_rsp1_rdata", bus.rsp1_rdata, 256'h0F);
        step();

        // Round-robin from reset, both always valid with single-beat reads
        do_reset();
        set_req(0, 1, 0, 1, 10'h003, '1, '0);
        set_req(1, 1, 0, 1, 10'h007, '1, '0);
        apply();
        for (int i = 0; i < 8; i++) begin
            #3;
            check("t3_grant0", bus.req0_ready, (i % 2) == 0);
            check("t3_grant1", bus.req1_ready, (i % 2) == 1);
            step();
        end
        v = '0; apply(); step();

        // Burst lock: req0 four beats with a gap after beat 2, req1 valid throughout
        do_reset();
        set_req(1, 1, 0, 1, 10'h009, '1, '0);
        set_req(0, 1, 0, 0, 10'h020, '1, '0); apply(); step();
        set_req(0, 1, 1, 0, 10'h021, rnd256(), rnd256()); apply(); step();
        v[0] = 0; apply(); #3;
        check("t4_gap_ready1", bus.req1_ready, 0);
        step();
        set_req(0, 1, 0, 0, 10'h021, '1, '0); apply(); step();
        set_req(0, 1, 0, 1, 10'h022, '1, '0); apply(); step();
        v[0] = 0; apply(); #3;
        check("t4_after_ready1", bus.req1_ready, 1);
        step();
        v = '0; apply(); step(); step();

        // Reset while LOCK0 with a read outstanding
        set_req(0, 1, 0, 0, 10'h004, '1, '0); apply(); step();
        RST = 1'b1;
        v[0] = 0;
        set_req(1, 1, 0, 1, 10'h006, '1, '0);
        apply(); #3;
        check("t5_rsp0", bus.rsp0_valid, 0);
        check("t5_csn", bus.CSn, 1);
        step(); step();
        RST = 1'b0; #3;
        check("t5_ready1", bus.req1_ready, 1);
        step();
        v = '0; apply(); step();

        // Randomized bursts with gaps, mixed reads/writes, occasional reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
                continue;
            end
            for (int n = 0; n < 2; n++) begin
                if (!v[n] || acc[n]) begin
                    if ($urandom_range(0, 9) < 6) begin
                        if (rem[n] == 0) rem[n] = $urandom_range(1, 4);
                        rem[n]--;
                        set_req(n, 1, $urandom_range(0, 1), rem[n] == 0,
                                AW'($urandom_range(0, 31)), rnd256(), rnd256());
                    end else begin
                        v[n] = 0;
                    end
                end
            end
            apply();
            step();
        end

        v = '0; apply();
        for (int i = 0; i < 4; i++) step();
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
